seq_det_arbiter: RTL and testbench

Two-requester round-robin scheduler for a shared serial sequence-detector FSM (single-bit input `in`, outputs Z1/Z2). Each requester presents a WIDTH-bit word. The winner's word is shifted LSB-first into the detector after a one-cycle detector clear. The Z1 and Z2 pulses produced during the job are counted and returned with a one-cycle `done` strobe. The block sits between the lab's stimulus sources and the detector, replacing hand-driven `in` stimulus.

---
 rtl/seq_det_arb_pkg.sv | 14 +
 rtl/rr_arb2.sv | 31 +++
 rtl/seq_det_arbiter.sv | 112 +++++++++++
 tb/tb_seq_det_arbiter.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_det_arb_pkg.sv
// Shared types and defaults for the sequence-detector job arbiter.
package seq_det_arb_pkg;

    localparam int DEF_WIDTH = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        SHIFT = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick; `last` remembers the most recent winner.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       upd,
    input  logic       upd_idx,
    output logic       pick
);

    logic last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last <= 1'b1;
        end else if (upd) begin
            last <= upd_idx;
        end
    end

    // On a tie the requester that did not win last time goes next.
    always_comb begin
        pick = 1'b0;
        case (req)
            2'b10:   pick = 1'b1;
            2'b11:   pick = ~last;
            default: pick = 1'b0;
        endcase
    end

endmodule

// File: rtl/seq_det_arbiter.sv
// Round-robin job scheduler feeding words LSB-first into a shared sequence
// detector and counting its Z1/Z2 hits per job.
//
//   state | meaning
//   IDLE  | waiting for a request; winner picked and latched on exit
//   CLEAR | one-cycle detector clear, counters zeroed
//   SHIFT | WIDTH cycles driving det_in from the shift register
//   DRAIN | one cycle to catch the Moore response to the last bit
//   DONE  | one-cycle done strobe, round-robin pointer updated
module seq_det_arbiter
    import seq_det_arb_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req,
    input  logic [WIDTH-1:0] data0,
    input  logic [WIDTH-1:0] data1,
    output logic [1:0]       grant,
    output logic             busy,
    output logic             done,
    output logic             owner,
    output logic [CNT_W-1:0] z1_cnt,
    output logic [CNT_W-1:0] z2_cnt,
    output logic             det_clr,
    output logic             det_in,
    input  logic             det_z1,
    input  logic             det_z2
);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] shreg;
    logic [CNT_W-1:0] bit_idx;
    logic             last_bit;
    logic             pick;
    logic             arb_upd;

    assign last_bit = (bit_idx == CNT_W'(WIDTH - 1));
    assign arb_upd  = (state == DONE);

    rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .upd     (arb_upd),
        .upd_idx (owner),
        .pick    (pick)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (|req) state_nxt = CLEAR;
            CLEAR:   state_nxt = SHIFT;
            SHIFT:   if (last_bit) state_nxt = DRAIN;
            DRAIN:   state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            grant   <= 2'b00;
            owner   <= 1'b0;
            shreg   <= '0;
            bit_idx <= '0;
            z1_cnt  <= '0;
            z2_cnt  <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (|req) begin
                        grant <= {pick, ~pick};
                        shreg <= pick ? data1 : data0;
                    end
                end
                CLEAR: begin
                    z1_cnt  <= '0;
                    z2_cnt  <= '0;
                    bit_idx <= '0;
                end
                SHIFT: begin
                    shreg   <= shreg >> 1;
                    bit_idx <= bit_idx + CNT_W'(1);
                    if (det_z1) z1_cnt <= z1_cnt + CNT_W'(1);
                    // det_z2 on the first shift cycle reflects the cleared detector, not job data.
                    if (det_z2 && bit_idx != '0) z2_cnt <= z2_cnt + CNT_W'(1);
                end
                DRAIN: begin
                    if (det_z2) z2_cnt <= z2_cnt + CNT_W'(1);
                    owner <= grant[1];
                end
                DONE: begin
                    grant <= 2'b00;
                end
                default: ;
            endcase
        end
    end

    assign busy    = (state != IDLE);
    assign done    = (state == DONE);
    assign det_clr = (state == CLEAR);
    assign det_in  = (state == SHIFT) && shreg[0];

endmodule

// File: tb/tb_seq_det_arbiter.sv
// Randomized bench for seq_det_arbiter with a stub detector (Z1 = in, Z2 = in delayed).
module tb_seq_det_arbiter;

    localparam int W  = 8;
    localparam int CW = $clog2(W + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    req;
    logic [W-1:0]  data0, data1;
    logic [1:0]    grant;
    logic          busy, done, owner;
    logic [CW-1:0] z1_cnt, z2_cnt;
    logic          det_clr, det_in, det_z1, det_z2;

    int   total = 0;
    int   bad   = 0;
    logic model_last;

    // observations of one job, filled by observe_job
    int           ob_wait, ob_glen, ob_done_cnt, ob_done_idx, ob_clr_bad, ob_busy_bad;
    int           ob_z1, ob_z2;
    logic         ob_timeout, ob_owner;
    logic [1:0]   ob_g;
    logic [W-1:0] ob_bits;

    seq_det_arbiter #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .req(req), .data0(data0), .data1(data1),
        .grant(grant), .busy(busy), .done(done), .owner(owner),
        .z1_cnt(z1_cnt), .z2_cnt(z2_cnt), .det_clr(det_clr), .det_in(det_in),
        .det_z1(det_z1), .det_z2(det_z2)
    );

    always #5 clk = ~clk;

    assign det_z1 = det_in;
    always @(posedge clk or posedge rst) begin
        if (rst) det_z2 <= 1'b0;
        else     det_z2 <= det_in;
    end

    function automatic logic model_pick(input logic [1:0] r, input logic lst);
        if (r == 2'b01) return 1'b0;
        if (r == 2'b10) return 1'b1;
        return !lst;
    endfunction

    // Watches one job from grant rise to grant fall, sampling on falling edges.
    task automatic observe_job();
        int idx;
        ob_wait = 0; ob_timeout = 0; ob_glen = 0; ob_done_cnt = 0; ob_done_idx = -1;
        ob_clr_bad = 0; ob_busy_bad = 0; ob_bits = '0; ob_g = 2'b00; ob_owner = 1'b0;
        ob_z1 = -1; ob_z2 = -1;
        @(negedge clk);
        while (grant == 2'b00 && ob_wait < 20) begin
            ob_wait++;
            @(negedge clk);
        end
        if (grant == 2'b00) begin
            ob_timeout = 1'b1;
            return;
        end
        ob_g = grant;
        idx  = 0;
        while (grant != 2'b00 && idx < 40) begin
            if (det_clr !== (idx == 0)) ob_clr_bad++;
            if (busy !== 1'b1 || grant !== ob_g) ob_busy_bad++;
            if (idx >= 1 && idx <= W) ob_bits = {det_in, ob_bits[W-1:1]};
            if (done === 1'b1) begin
                ob_done_cnt++;
                ob_done_idx = idx;
                ob_owner    = owner;
                ob_z1       = int'(z1_cnt);
                ob_z2       = int'(z2_cnt);
            end
            idx++;
            @(negedge clk);
        end
        ob_glen = idx;
        if (grant != 2'b00) ob_timeout = 1'b1;
        if (busy !== 1'b0) ob_busy_bad++;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 2'b00; data0 = '0; data1 = '0;
        #1;
        total++;
        if (grant !== 2'b00) begin bad++; $display("FAIL reset_grant: got %b want 00", grant); end
        total++;
        if ({busy, done, owner, z1_cnt, z2_cnt, det_clr, det_in} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got busy=%b done=%b owner=%b z1=%0d z2=%0d clr=%b in=%b want all 0",
                     busy, done, owner, z1_cnt, z2_cnt, det_clr, det_in);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_last = 1'b1;
    endtask

    task automatic test_single();
        req = 2'b01; data0 = 8'b1011_0010; data1 = 8'h5A;
        fork
            observe_job();
            begin
                repeat (2) @(negedge clk);
                req = 2'b00;
                data0 = 8'h00;
            end
        join
        model_last = 1'b0;
        total++;
        if (ob_timeout) begin bad++; $display("FAIL single_timeout: got timeout want job"); end
        total++;
        if (ob_wait != 0) begin bad++; $display("FAIL single_latency: got %0d want 0", ob_wait); end
        total++;
        if (ob_g !== 2'b01) begin bad++; $display("FAIL single_grant: got %b want 01", ob_g); end
        total++;
        if (ob_glen != W + 3) begin bad++; $display("FAIL single_glen: got %0d want %0d", ob_glen, W + 3); end
        total++;
        if (ob_bits !== 8'b1011_0010) begin bad++; $display("FAIL single_bits: got %h want b2", ob_bits); end
        total++;
        if (ob_done_cnt != 1 || ob_done_idx != W + 2) begin
            bad++; $display("FAIL single_done: got cnt=%0d idx=%0d want 1 %0d", ob_done_cnt, ob_done_idx, W + 2);
        end
        total++;
        if (ob_owner !== 1'b0 || ob_z1 != 4 || ob_z2 != 4) begin
            bad++; $display("FAIL single_result: got owner=%b z1=%0d z2=%0d want 0 4 4", ob_owner, ob_z1, ob_z2);
        end
        total++;
        if (ob_clr_bad != 0 || ob_busy_bad != 0) begin
            bad++; $display("FAIL single_clr_busy: got clr_bad=%0d busy_bad=%0d want 0 0", ob_clr_bad, ob_busy_bad);
        end
    endtask

    task automatic test_tie();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_last = 1'b1;
        req = 2'b11; data0 = 8'hFF; data1 = 8'h00;
        observe_job();
        total++;
        if (ob_timeout || ob_g !== 2'b01 || ob_owner !== 1'b0 || ob_z1 != 8 || ob_z2 != 8) begin
            bad++; $display("FAIL tie_first: got g=%b owner=%b z1=%0d z2=%0d to=%b want 01 0 8 8 0",
                            ob_g, ob_owner, ob_z1, ob_z2, ob_timeout);
        end
        fork
            observe_job();
            begin
                repeat (2) @(negedge clk);
                req = 2'b00;
            end
        join
        model_last = 1'b1;
        total++;
        if (ob_timeout || ob_g !== 2'b10 || ob_owner !== 1'b1 || ob_z1 != 0 || ob_z2 != 0) begin
            bad++; $display("FAIL tie_second: got g=%b owner=%b z1=%0d z2=%0d to=%b want 10 1 0 0 0",
                            ob_g, ob_owner, ob_z1, ob_z2, ob_timeout);
        end
        total++;
        if (ob_wait != 0) begin bad++; $display("FAIL tie_gap: got %0d extra idle want 0", ob_wait); end
    endtask

    task automatic test_fairness();
        logic         exp_pick;
        logic [W-1:0] exp_word;
        req = 2'b11; data0 = W'($urandom); data1 = W'($urandom);
        for (int j = 0; j < 4; j++) begin
            exp_pick = model_pick(req, model_last);
            exp_word = exp_pick ? data1 : data0;
            fork
                observe_job();
                begin
                    repeat (3) @(negedge clk);
                    data0 = W'($urandom);
                    data1 = W'($urandom);
                    if (j == 3) req = 2'b00;
                end
            join
            model_last = exp_pick;
            total++;
            if (ob_timeout || ob_g !== {exp_pick, !exp_pick} || ob_owner !== exp_pick) begin
                bad++; $display("FAIL fair_grant%0d: got g=%b owner=%b to=%b want g=%b",
                                j, ob_g, ob_owner, ob_timeout, {exp_pick, !exp_pick});
            end
            total++;
            if (ob_bits !== exp_word || ob_z1 != $countones(exp_word) || ob_z2 != $countones(exp_word)) begin
                bad++; $display("FAIL fair_data%0d: got bits=%h z1=%0d z2=%0d want %h %0d",
                                j, ob_bits, ob_z1, ob_z2, exp_word, $countones(exp_word));
            end
            total++;
            if (ob_wait != 0 || ob_clr_bad != 0 || ob_glen != W + 3) begin
                bad++; $display("FAIL fair_timing%0d: got wait=%0d clr_bad=%0d glen=%0d want 0 0 %0d",
                                j, ob_wait, ob_clr_bad, ob_glen, W + 3);
            end
        end
    endtask

    task automatic test_drop_random();
        logic [1:0]   r;
        logic         exp_pick;
        logic [W-1:0] exp_word;
        int           drop_at;
        for (int j = 0; j < 6; j++) begin
            r        = 2'($urandom_range(1, 3));
            data0    = W'($urandom);
            data1    = W'($urandom);
            req      = r;
            exp_pick = model_pick(r, model_last);
            exp_word = exp_pick ? data1 : data0;
            drop_at  = $urandom_range(2, W + 2);
            fork
                observe_job();
                begin
                    repeat (drop_at) @(negedge clk);
                    req   = 2'b00;
                    data0 = ~data0;
                    data1 = ~data1;
                end
            join
            model_last = exp_pick;
            total++;
            if (ob_timeout || ob_g !== {exp_pick, !exp_pick} || ob_owner !== exp_pick
                || ob_done_cnt != 1 || ob_done_idx != W + 2 || ob_glen != W + 3) begin
                bad++; $display("FAIL drop_job%0d: got g=%b owner=%b done=%0d@%0d glen=%0d to=%b want g=%b done@%0d",
                                j, ob_g, ob_owner, ob_done_cnt, ob_done_idx, ob_glen, ob_timeout,
                                {exp_pick, !exp_pick}, W + 2);
            end
            total++;
            if (ob_bits !== exp_word || ob_z1 != $countones(exp_word) || ob_z2 != $countones(exp_word)
                || ob_clr_bad != 0 || ob_busy_bad != 0) begin
                bad++; $display("FAIL drop_data%0d: got bits=%h z1=%0d z2=%0d clr_bad=%0d busy_bad=%0d want %h %0d",
                                j, ob_bits, ob_z1, ob_z2, ob_clr_bad, ob_busy_bad, exp_word, $countones(exp_word));
            end
            repeat (2) @(negedge clk);
        end
    endtask

    task automatic test_reset_mid();
        int           dones;
        logic [W-1:0] w1;
        req = 2'b01; data0 = 8'hAA;
        repeat (5) @(negedge clk);
        req = 2'b00;
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL midrst_busy_before: got %b want 1", busy); end
        rst = 1'b1;
        #1;
        total++;
        if ({grant, busy, done, owner, z1_cnt, z2_cnt, det_clr, det_in} !== '0) begin
            bad++; $display("FAIL midrst_outputs: got g=%b busy=%b done=%b owner=%b z1=%0d z2=%0d clr=%b in=%b want all 0",
                            grant, busy, done, owner, z1_cnt, z2_cnt, det_clr, det_in);
        end
        @(negedge clk);
        rst = 1'b0;
        model_last = 1'b1;
        dones = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) dones++;
        end
        total++;
        if (dones != 0) begin bad++; $display("FAIL midrst_no_done: got %0d active cycles want 0", dones); end
        w1 = W'($urandom);
        req = 2'b10; data1 = w1;
        fork
            observe_job();
            begin
                repeat (2) @(negedge clk);
                req = 2'b00;
            end
        join
        model_last = 1'b1;
        total++;
        if (ob_timeout || ob_g !== 2'b10 || ob_owner !== 1'b1 || ob_bits !== w1 || ob_z1 != $countones(w1)) begin
            bad++; $display("FAIL midrst_after: got g=%b owner=%b bits=%h z1=%0d to=%b want 10 1 %h %0d",
                            ob_g, ob_owner, ob_bits, ob_z1, ob_timeout, w1, $countones(w1));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single();
        test_tie();
        test_fairness();
        test_drop_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
